// File: rtl/oci_debug_access_sequencer.sv
// oci_debug_access_sequencer: turns OCI JTAG memory strobes into single memory requests.
// One pending command can be buffered. The optional request timeout is enabled with OCI_SEQ_TIMEOUT_EN.
`default_nettype none

module oci_debug_access_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_timeout,
    input  logic              err_clr
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR_REQ = 2'd1, S_RD_REQ = 2'd2} state_t;

    localparam logic [1:0] c_K_A = 2'd0;
    localparam logic [1:0] c_K_B = 2'd1;
    localparam logic [1:0] c_K_N = 2'd2;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, r_addr, r_pend_addr;
    logic [31:0]       r_wdata, r_mon, r_pend_data;
    logic              r_we, r_incr, r_pend_vld, r_pend_rd, r_err_ovf;
    logic [1:0]        r_pend_kind;

    logic              w_idle, w_new_vld, w_prio_drop, w_full_drop, w_store;
    logic              w_run_pend, w_run_new, w_exec, w_ack, w_tmo;
    logic [1:0]        w_new_kind, w_ex_kind;
    logic [ADDR_W-1:0] w_ex_addr;
    logic              w_ex_rd;
    logic [31:0]       w_ex_data;

    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_new_vld   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        w_new_kind  = take_action_ocimem_a ? c_K_A : (take_action_ocimem_b ? c_K_B : c_K_N);
        w_prio_drop = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);
        w_run_pend  = w_idle & r_pend_vld;
        w_run_new   = w_idle & ~r_pend_vld & w_new_vld;
        w_exec      = w_run_pend | w_run_new;
        // The buffer slot frees up in the same cycle its command runs.
        w_store     = w_new_vld & ((~w_idle & ~r_pend_vld) | w_run_pend);
        w_full_drop = w_new_vld & ~w_idle & r_pend_vld;
        w_ex_kind   = w_run_pend ? r_pend_kind : w_new_kind;
        w_ex_addr   = w_run_pend ? r_pend_addr : jdo[17+ADDR_W:18];
        w_ex_rd     = w_run_pend ? r_pend_rd   : jdo[35];
        w_ex_data   = w_run_pend ? r_pend_data : jdo[34:3];
        w_ack       = ~w_idle & mem_ack;
        w_state_nxt = r_state;
        if (w_ack || w_tmo) begin
            w_state_nxt = S_IDLE;
        end else if (w_exec) begin
            case (w_ex_kind)
                c_K_A:   w_state_nxt = w_ex_rd ? S_RD_REQ : S_IDLE;
                c_K_B:   w_state_nxt = S_WR_REQ;
                default: w_state_nxt = S_RD_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_incr      <= 1'b0;
            r_mon       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_kind <= c_K_A;
            r_pend_addr <= '0;
            r_pend_rd   <= 1'b0;
            r_pend_data <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_exec) begin
                case (w_ex_kind)
                    c_K_A: begin
                        r_ptr <= w_ex_addr;
                        if (w_ex_rd) begin
                            r_addr <= w_ex_addr;
                            r_we   <= 1'b0;
                            r_incr <= 1'b0;
                        end
                    end
                    c_K_B: begin
                        r_addr  <= r_ptr;
                        r_we    <= 1'b1;
                        r_wdata <= w_ex_data;
                        r_incr  <= 1'b1;
                    end
                    default: begin
                        r_addr <= r_ptr;
                        r_we   <= 1'b0;
                        r_incr <= 1'b1;
                    end
                endcase
            end
            if (w_ack) begin
                if (r_incr) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
                if (r_state == S_RD_REQ) begin
                    r_mon <= mem_rdata;
                end
            end
            if (w_run_pend) begin
                r_pend_vld <= 1'b0;
            end
            if (w_store) begin
                r_pend_vld  <= 1'b1;
                r_pend_kind <= w_new_kind;
                r_pend_addr <= jdo[17+ADDR_W:18];
                r_pend_rd   <= jdo[35];
                r_pend_data <= jdo[34:3];
            end
            // A new error in the clearing cycle must win.
            if (err_clr) begin
                r_err_ovf <= 1'b0;
            end
            if (w_prio_drop || w_full_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

`ifdef OCI_SEQ_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err_tmo;
    logic       w_unused;

    assign w_tmo    = ~w_idle & ~mem_ack & (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign w_unused = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err_tmo <= 1'b0;
        end else begin
            if (w_exec) begin
                r_tmo_cnt <= '0;
            end else if (!w_idle) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (err_clr) begin
                r_err_tmo <= 1'b0;
            end
            if (w_tmo) begin
                r_err_tmo <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_tmo;
`else
    logic w_unused;

    assign w_tmo       = 1'b0;
    assign w_unused    = ^{jdo[37:36], jdo[2:0], 8'(TIMEOUT_CYCLES)};
    assign err_timeout = 1'b0;
`endif

    assign mem_req      = ~w_idle;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign MonDReg      = r_mon;
    assign busy         = ~w_idle | r_pend_vld;
    assign err_overflow = r_err_ovf;

endmodule

`default_nettype wire
